// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Brief    : Game-state sequencer: IDLE/PLAY/PAUSE/OVER, lives, immunity, levels.
// Revision : 1.0
// ============================================================================
module game_sequencer #(
  parameter int LIVES_INIT      = 3,
  parameter int INVULN_TICKS    = 32,
  parameter int KILLS_PER_LEVEL = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       kill,
  output logic [1:0] state,
  output logic       play_en,
  output logic       clear,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       invuln,
  output logic [5:0] spawn_div
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] C_LIVES_INIT = 2'(LIVES_INIT);
  localparam logic [5:0] C_INVULN     = 6'(INVULN_TICKS);
  localparam logic [5:0] C_KILL_LAST  = 6'(KILLS_PER_LEVEL - 1);

  logic [2:0] r_start_sync;
  logic [2:0] r_pause_sync;
  logic [1:0] r_settle;
  logic       r_start_arm;
  logic       r_pause_arm;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_lives, w_lives_nxt;
  logic [2:0] r_level, w_level_nxt;
  logic [5:0] r_kills, w_kills_nxt;
  logic [5:0] r_imm, w_imm_nxt;
  logic       r_clear, w_clear_nxt;

  logic w_start_rise;
  logic w_pause_rise;
  logic w_hit_ok;

  // A rise only counts once the synchronizer has shown the input low after
  // reset, so a button held through reset release never fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_sync <= 3'b000;
      r_pause_sync <= 3'b000;
      r_settle     <= 2'b00;
      r_start_arm  <= 1'b0;
      r_pause_arm  <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[1:0], start};
      r_pause_sync <= {r_pause_sync[1:0], pause};
      r_settle     <= {r_settle[0], 1'b1};
      if (r_settle[1] && !r_start_sync[1]) r_start_arm <= 1'b1;
      if (r_settle[1] && !r_pause_sync[1]) r_pause_arm <= 1'b1;
    end
  end

  assign w_start_rise = r_start_sync[1] & ~r_start_sync[2] & r_start_arm;
  assign w_pause_rise = r_pause_sync[1] & ~r_pause_sync[2] & r_pause_arm;
  assign w_hit_ok     = hit & (r_imm == 6'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_lives <= 2'd0;
      r_level <= 3'd0;
      r_kills <= 6'd0;
      r_imm   <= 6'd0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lives <= w_lives_nxt;
      r_level <= w_level_nxt;
      r_kills <= w_kills_nxt;
      r_imm   <= w_imm_nxt;
      r_clear <= w_clear_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_level_nxt = r_level;
    w_kills_nxt = r_kills;
    w_imm_nxt   = r_imm;
    w_clear_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = S_PLAY;
          w_lives_nxt = C_LIVES_INIT;
          w_level_nxt = 3'd0;
          w_kills_nxt = 6'd0;
          w_imm_nxt   = 6'd0;
          w_clear_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        // A fatal hit ends the game outright: same-cycle kills and pause are dropped.
        if (w_hit_ok && (r_lives == 2'd1)) begin
          w_lives_nxt = 2'd0;
          w_state_nxt = S_OVER;
        end else begin
          if (w_hit_ok) begin
            w_lives_nxt = r_lives - 2'd1;
            w_imm_nxt   = C_INVULN;
          end else if (tick && (r_imm != 6'd0)) begin
            w_imm_nxt = r_imm - 6'd1;
          end
          if (kill) begin
            if (r_kills == C_KILL_LAST) begin
              w_kills_nxt = 6'd0;
              if (r_level != 3'd7) w_level_nxt = r_level + 3'd1;
            end else begin
              w_kills_nxt = r_kills + 6'd1;
            end
          end
          if (w_pause_rise) w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_pause_rise) w_state_nxt = S_PLAY;
      end
      S_OVER: begin
        if (w_start_rise) w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign state     = r_state;
  assign play_en   = (r_state == S_PLAY);
  assign clear     = r_clear;
  assign lives     = r_lives;
  assign level     = r_level;
  assign invuln    = (r_imm != 6'd0);
  assign spawn_div = 6'd40 - {1'b0, r_level, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Brief    : Scoreboard bench for game_sequencer against a rule-level model.
// Revision : 1.0
// ============================================================================
module tb_game_sequencer;

    localparam int C_TIMEOUT = 1000000;

    logic       clk = 1'b0;
    logic       rst, tick, start, pause, hit, kill;
    logic [1:0] state;
    logic       play_en, clear;
    logic [1:0] lives;
    logic [2:0] level;
    logic       invuln;
    logic [5:0] spawn_div;

    game_sequencer #(
        .LIVES_INIT(3), .INVULN_TICKS(32), .KILLS_PER_LEVEL(16)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .hit(hit), .kill(kill), .state(state), .play_en(play_en), .clear(clear),
        .lives(lives), .level(level), .invuln(invuln), .spawn_div(spawn_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int clr; int lv; int lvl; int inv; int spd; int pen;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    event ev_async;

    int m_state, m_lives, m_level, m_kills, m_imm, m_clear;
    bit start_hist[$];
    bit pause_hist[$];

    function automatic void model_reset();
        m_state = 0; m_lives = 0; m_level = 0; m_kills = 0; m_imm = 0; m_clear = 0;
        start_hist.delete();
        pause_hist.delete();
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.st  = m_state;
        e.clr = m_clear;
        e.lv  = m_lives;
        e.lvl = m_level;
        e.inv = (m_imm > 0) ? 1 : 0;
        e.spd = 40 - 4 * m_level;
        e.pen = (m_state == 1) ? 1 : 0;
        exp_q.push_back(e);
    endfunction

    function automatic bit rose(input bit h[$]);
        int k;
        k = h.size();
        return (k >= 4) && h[k-3] && !h[k-4];
    endfunction

    function automatic void model_step();
        bit sr, pr, hit_ok;
        start_hist.push_back(start);
        pause_hist.push_back(pause);
        sr = rose(start_hist);
        pr = rose(pause_hist);
        m_clear = 0;
        case (m_state)
            0: if (sr) begin
                m_state = 1; m_lives = 3; m_level = 0; m_kills = 0; m_imm = 0; m_clear = 1;
            end
            1: begin
                hit_ok = hit && (m_imm == 0);
                if (hit_ok && m_lives == 1) begin
                    m_lives = 0;
                    m_state = 3;
                end else begin
                    if (hit_ok) begin
                        m_lives = m_lives - 1;
                        m_imm   = 32;
                    end else if (tick && m_imm > 0) begin
                        m_imm = m_imm - 1;
                    end
                    if (kill) begin
                        m_kills = m_kills + 1;
                        if (m_kills == 16) begin
                            m_kills = 0;
                            if (m_level < 7) m_level = m_level + 1;
                        end
                    end
                    if (pr) m_state = 2;
                end
            end
            2: if (pr) m_state = 1;
            default: if (sr) m_state = 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) model_reset();
        else model_step();
        push_exp();
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or ev_async);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                if (int'(state) != e.st || int'(clear) != e.clr || int'(lives) != e.lv ||
                    int'(level) != e.lvl || int'(invuln) != e.inv ||
                    int'(spawn_div) != e.spd || int'(play_en) != e.pen) begin
                    errors = errors + 1;
                    $display("FAIL outputs @%0t: got st=%0d clr=%0d lives=%0d lvl=%0d inv=%0d spd=%0d pen=%0d, exp st=%0d clr=%0d lives=%0d lvl=%0d inv=%0d spd=%0d pen=%0d",
                             $time, state, clear, lives, level, invuln, spawn_div, play_en,
                             e.st, e.clr, e.lv, e.lvl, e.inv, e.spd, e.pen);
                end
            end
        end
    end

    initial begin
        #C_TIMEOUT;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL timeout @%0t: stimulus did not complete", $time);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic check_reset_state(input string tag);
        checks = checks + 1;
        if (state !== 2'd0 || lives !== 2'd0 || level !== 3'd0 || clear !== 1'b0 ||
            invuln !== 1'b0 || play_en !== 1'b0 || spawn_div !== 6'd40) begin
            errors = errors + 1;
            $display("FAIL reset state (%s) @%0t: st=%0d lives=%0d lvl=%0d clr=%0d inv=%0d pen=%0d spd=%0d",
                     tag, $time, state, lives, level, clear, invuln, play_en, spawn_div);
        end
    endtask

    task automatic drive(input bit st, input bit pa, input bit t, input bit h, input bit k);
        @(posedge clk);
        #1;
        start = st; pause = pa; tick = t; hit = h; kill = k;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_state("mid-play async");
        model_reset();
        push_exp();
        -> ev_async;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    bit st_l, pa_l;

    initial begin
        rst = 1'b0; start = 1'b1; pause = 1'b0; tick = 1'b0; hit = 1'b0; kill = 1'b0;
        #1;
        check_reset_state("power-on");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;

        repeat (8) drive(1, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0);
        repeat (6) drive(1, 0, 0, 0, 0);

        drive(1, 0, 0, 1, 0);
        for (int i = 0; i < 40; i++) drive(1, 0, 1, (i % 3) == 0, 0);

        repeat (4) drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 1, (i % 2) == 0, (i % 3) == 0);
        repeat (4) drive(1, 1, 0, 0, 0);
        repeat (40) drive(1, 0, 1, 0, 0);

        repeat (144) drive(1, 0, 0, 0, 1);
        repeat (5) drive(1, 0, 0, 0, 1);

        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 1);
        repeat (3) drive(1, 1, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0);
        repeat (6) drive(1, 0, 1, 0, 1);

        async_reset();
        repeat (4) drive(1, 0, 0, 0, 0);

        st_l = 1'b0;
        pa_l = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 14) == 0) st_l = ~st_l;
            if ($urandom_range(0, 24) == 0) pa_l = ~pa_l;
            drive(st_l, pa_l, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0));
        end

        repeat (3) drive(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
